// File: rtl/hilo_muldiv_unit.sv
// Multiply/divide unit that owns the architectural HI/LO registers.
// Fixed-latency multiplier and a 32-iteration restoring divider with a sign-fix cycle.
module hilo_muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] XALU_A,
  input  logic [31:0] XALU_B,
  input  logic        Intreq,
  output logic [31:0] XALU_HI,
  output logic [31:0] XALU_LO,
  output logic        XALU_Busy,
  output logic        mul_ok
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MUL   = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q;
  logic        mul_ok_q, mul_ok_d;
  // opa holds the multiplicand, or the dividend shifting into the quotient.
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic        sign_q, sign_d;
  logic        mul_op_q, mul_op_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;

  op_e         op;
  logic        is_signed_div;
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] product;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;

  assign op = op_e'(Op);

  // Low 64 bits of an unsigned product of sign-extended operands equal the signed product.
  assign mul_a_ext = {{32{sign_q & opa_q[31]}}, opa_q};
  assign mul_b_ext = {{32{sign_q & opb_q[31]}}, opb_q};
  assign product   = mul_a_ext * mul_b_ext;

  assign rem_shift = {rem_q, opa_q[31]};
  assign rem_diff  = rem_shift - {1'b0, opb_q};

  assign is_signed_div = (op == OP_DIV);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_ok_d  = mul_ok_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    sign_d    = sign_q;
    mul_op_d  = mul_op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;

    if (Intreq) begin
      // Abort wins over accept and over a same-edge commit.
      state_d  = S_IDLE;
      count_d  = 6'd0;
      mul_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start && (op != OP_RSVD)) begin
            mul_ok_d = 1'b0;
            case (op)
              OP_MTHI: hi_d = XALU_A;
              OP_MTLO: lo_d = XALU_A;
              OP_MULT, OP_MULTU, OP_MUL: begin
                opa_d    = XALU_A;
                opb_d    = XALU_B;
                sign_d   = (op != OP_MULTU);
                mul_op_d = (op == OP_MUL);
                count_d  = MUL_LAST;
                state_d  = S_MULT;
              end
              OP_DIV, OP_DIVU: begin
                opa_d     = (is_signed_div && XALU_A[31]) ? (~XALU_A + 32'd1) : XALU_A;
                opb_d     = (is_signed_div && XALU_B[31]) ? (~XALU_B + 32'd1) : XALU_B;
                rem_d     = 32'd0;
                quo_neg_d = is_signed_div && (XALU_A[31] ^ XALU_B[31]);
                rem_neg_d = is_signed_div && XALU_A[31];
                mul_op_d  = 1'b0;
                count_d   = DIV_LAST;
                state_d   = S_DIV;
              end
              default: ;
            endcase
          end
        end

        S_MULT: begin
          if (count_q == 6'd0) begin
            hi_d     = product[63:32];
            lo_d     = product[31:0];
            mul_ok_d = mul_op_q;
            state_d  = S_IDLE;
          end else begin
            count_d = count_q - 6'd1;
          end
        end

        S_DIV: begin
          // A zero divisor always subtracts, yielding all-ones quotient and remainder = dividend.
          opa_d = {opa_q[30:0], ~rem_diff[32]};
          rem_d = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
          if (count_q == 6'd0) begin
            state_d = S_FIX;
          end else begin
            count_d = count_q - 6'd1;
          end
        end

        S_FIX: begin
          lo_d    = quo_neg_q ? (~opa_q + 32'd1) : opa_q;
          hi_d    = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= S_IDLE;
      count_q   <= 6'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      mul_ok_q  <= 1'b0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      rem_q     <= 32'd0;
      sign_q    <= 1'b0;
      mul_op_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= (state_d != S_IDLE);
      mul_ok_q  <= mul_ok_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      sign_q    <= sign_d;
      mul_op_q  <= mul_op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign XALU_HI   = hi_q;
  assign XALU_LO   = lo_q;
  assign XALU_Busy = busy_q;
  assign mul_ok    = mul_ok_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, corner-case
// sequences (abort, async clear, held Start) and randomized ops against an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_LAT    = 33;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] XALU_A;
  logic [31:0] XALU_B;
  logic        Intreq;
  logic [31:0] XALU_HI;
  logic [31:0] XALU_LO;
  logic        XALU_Busy;
  logic        mul_ok;

  int n_vec = 0;
  int n_err = 0;

  hilo_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .Start    (Start),
    .Op       (Op),
    .XALU_A   (XALU_A),
    .XALU_B   (XALU_B),
    .Intreq   (Intreq),
    .XALU_HI  (XALU_HI),
    .XALU_LO  (XALU_LO),
    .XALU_Busy(XALU_Busy),
    .mul_ok   (mul_ok)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        mok;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Issue one op, count Busy cycles (bounded), then check HI/LO/mul_ok.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat, input logic mok);
    int cyc;
    Op = op; XALU_A = a; XALU_B = b; Start = 1'b1;
    step();
    Start = 1'b0; XALU_A = $urandom; XALU_B = $urandom;
    cyc = 0;
    while (XALU_Busy && cyc < 100) begin
      cyc++;
      step();
    end
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " HI"}, XALU_HI, hi);
    check({name, " LO"}, XALU_LO, lo);
    check({name, " mul_ok"}, 32'(mul_ok), 32'(mok));
  endtask

  // Architectural model: plain 64-bit arithmetic plus the divide-by-zero rules.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] hi, inout logic [31:0] lo, inout logic mok,
                        output int lat);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    lat = 0;
    if (op != 3'd7) mok = 1'b0;
    case (op)
      3'd0, 3'd4: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sp = sa * sb;
        hi = sp[63:32]; lo = sp[31:0];
        mok = (op == 3'd4);
        lat = MUL_CYCLES;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0];
        lat = MUL_CYCLES;
      end
      3'd2: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin
          lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          hi = a;
        end else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          sq = sa / sb; sr = sa % sb;
          lo = sq[31:0]; hi = sr[31:0];
        end
      end
      3'd3: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] saved_lo;
    logic [31:0] m_hi, m_lo;
    logic        m_mok;
    int          m_lat;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
    vecs[3]  = '{3'd3, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 32'hFFFF_FFFF, 33, 1'b0};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0};
    vecs[5]  = '{3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0001, 33, 1'b0};
    vecs[6]  = '{3'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 33, 1'b0};
    vecs[7]  = '{3'd4, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 4, 1'b1};
    vecs[8]  = '{3'd7, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_0000, 32'h0000_002A, 0, 1'b1};
    vecs[9]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_002A, 0, 1'b0};
    vecs[10] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0};
    vecs[11] = '{3'd6, 32'h0BAD_F00D, 32'h0000_0000, 32'h0000_0001, 32'h0BAD_F00D, 0, 1'b0};
    vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, 1'b0};
    vecs[13] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 4, 1'b0};

    Clr = 1'b1; Start = 1'b0; Op = 3'd0; XALU_A = '0; XALU_B = '0; Intreq = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset HI", XALU_HI, 32'd0);
    check("reset LO", XALU_LO, 32'd0);
    check("reset busy", 32'(XALU_Busy), 32'd0);
    check("reset mul_ok", 32'(mul_ok), 32'd0);
    Clr = 1'b0;
    step();

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].mok);

    // MUL with Start held through Busy and new operands: no re-issue, mul_ok then holds.
    Op = 3'd4; XALU_A = 32'd7; XALU_B = 32'd6; Start = 1'b1;
    step();
    XALU_A = 32'd100; XALU_B = 32'd100;
    for (int i = 0; i < MUL_CYCLES; i++) begin
      check($sformatf("held busy %0d", i), 32'(XALU_Busy), 32'd1);
      check($sformatf("held mul_ok %0d", i), 32'(mul_ok), 32'd0);
      step();
    end
    Start = 1'b0;
    check("held done busy", 32'(XALU_Busy), 32'd0);
    check("held LO", XALU_LO, 32'h0000_002A);
    repeat (6) step();
    check("held mul_ok stall", 32'(mul_ok), 32'd1);
    run_op("mtlo clears mul_ok", 3'd6, 32'h99, 32'h0, 32'h0, 32'h99, 0, 1'b0);

    // Abort a DIVU at iteration 10.
    run_op("mthi pre", 3'd5, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h99, 0, 1'b0);
    saved_lo = XALU_LO;
    Op = 3'd3; XALU_A = 32'd1000; XALU_B = 32'd7; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (9) step();
    check("abort pre busy", 32'(XALU_Busy), 32'd1);
    Intreq = 1'b1;
    step();
    Intreq = 1'b0;
    check("abort busy", 32'(XALU_Busy), 32'd0);
    check("abort HI", XALU_HI, 32'h1234_5678);
    check("abort mul_ok", 32'(mul_ok), 32'd0);
    repeat (40) step();
    check("abort late HI", XALU_HI, 32'h1234_5678);
    check("abort late LO", XALU_LO, saved_lo);

    // Intreq on the very edge a MUL would commit.
    Op = 3'd4; XALU_A = 32'd3; XALU_B = 32'd5; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (MUL_CYCLES - 1) step();
    Intreq = 1'b1;
    step();
    Intreq = 1'b0;
    check("commit abort busy", 32'(XALU_Busy), 32'd0);
    check("commit abort LO", XALU_LO, saved_lo);
    check("commit abort HI", XALU_HI, 32'h1234_5678);
    check("commit abort mul_ok", 32'(mul_ok), 32'd0);

    // Intreq in IDLE clears mul_ok and blocks a same-cycle accept.
    run_op("mul for idle intreq", 3'd4, 32'd2, 32'd2, 32'd0, 32'd4, MUL_CYCLES, 1'b1);
    Intreq = 1'b1;
    step();
    check("idle intreq mul_ok", 32'(mul_ok), 32'd0);
    Op = 3'd6; XALU_A = 32'h0000_CAFE; Start = 1'b1;
    step();
    check("blocked mtlo LO", XALU_LO, 32'd4);
    Op = 3'd2;
    step();
    check("blocked div busy", 32'(XALU_Busy), 32'd0);
    Start = 1'b0; Intreq = 1'b0;
    step();

    // Asynchronous Clr between edges in the middle of a DIV.
    run_op("mthi before clr", 3'd5, 32'hAAAA_AAAA, 32'h0, 32'hAAAA_AAAA, 32'd4, 0, 1'b0);
    Op = 3'd2; XALU_A = 32'd100; XALU_B = 32'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (5) step();
    #2 Clr = 1'b1;
    #1;
    check("clr HI", XALU_HI, 32'd0);
    check("clr LO", XALU_LO, 32'd0);
    check("clr busy", 32'(XALU_Busy), 32'd0);
    check("clr mul_ok", 32'(mul_ok), 32'd0);
    @(negedge Clk);
    Clr = 1'b0;
    run_op("mtlo after clr", 3'd6, 32'd5, 32'd0, 32'd0, 32'd5, 0, 1'b0);
    repeat (40) step();
    check("no stale HI", XALU_HI, 32'd0);
    check("no stale LO", XALU_LO, 32'd5);

    // Randomized ops against the model.
    m_hi = 32'd0; m_lo = 32'd5; m_mok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      ref_op(r_op, r_a, r_b, m_hi, m_lo, m_mok, m_lat);
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, m_hi, m_lo, m_lat, m_mok);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
